// File: rtl/apb_requester_if.sv
// Command, APB and response signals of the APB requester, grouped as one bundle.
// The master modport is the requester's view. The slave modport is the view of
// the surrounding controller and APB completer.
interface apb_requester_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) ();
    // command port
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    // APB segment
    logic                  psel_x;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    // response strobe
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output psel_x, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  psel_x, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout
    );
endinterface

// File: rtl/apb_requester.sv
// APB requester: takes single read/write commands on a valid/ready port.
// It runs the IDLE/SETUP/ACCESS sequence on one psel_x line and returns the
// result on a one-cycle response strobe. A transfer whose completer holds
// pready low for TIMEOUT_CYCLES ACCESS cycles is aborted.
module apb_requester #(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16    // legal range 1..255
) (
    input  logic           pclk,
    input  logic           preset,
    apb_requester_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d, cnt_inc;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  cmd_ready;
    logic                  accept;

    // cmd_ready is the only output that is not a flop. A completing ACCESS cycle
    // must accept the next command in the same cycle as pready. That is what keeps
    // back-to-back transfers at one per two cycles. It is a decode of the state
    // register plus pready.
    assign cmd_ready = (state_q == IDLE) || ((state_q == ACCESS) && bus.pready);
    assign accept    = cmd_ready && bus.cmd_valid;

    // Saturating increment: the counter never wraps back to zero.
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    // Normal completion. pslverr and prdata are only looked at here.
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.pslverr;
                    if (!pwrite_q && !bus.pslverr) rsp_rdata_d = bus.prdata;
                    state_d = accept ? SETUP : IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_LIMIT) begin
                        state_d       = IDLE;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The bus fields are latched only on acceptance. They stay frozen from SETUP
        // through the last ACCESS cycle.
        if (accept) begin
            cnt_d    = '0;
            pwrite_d = bus.cmd_write;
            paddr_d  = bus.cmd_addr;
            pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
        end

        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge pclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (preset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.psel_x      = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester with TIMEOUT_CYCLES = 4. Inputs change 1 ns
// after a rising edge. Registered outputs are checked at that same point.
// cmd_ready is checked 1 ns after the inputs that feed it have changed.
module tb_apb_requester;
    logic pclk;
    logic preset;
    int   n_checks = 0;
    int   n_fails  = 0;

    apb_requester_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();

    apb_requester #(
        .ADDR_WIDTH     (3),
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (4)
    ) u_dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus.master)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Abort a run that somehow stops advancing.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [2:0] addr, input logic [7:0] wdata);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
    endtask

    task automatic check_idle_rst(input string tag);
        check({tag, " psel_x"},      32'(bus.psel_x),      32'h0);
        check({tag, " penable"},     32'(bus.penable),     32'h0);
        check({tag, " pwrite"},      32'(bus.pwrite),      32'h0);
        check({tag, " paddr"},       32'(bus.paddr),       32'h0);
        check({tag, " pwdata"},      32'(bus.pwdata),      32'h0);
        check({tag, " rsp_valid"},   32'(bus.rsp_valid),   32'h0);
        check({tag, " rsp_rdata"},   32'(bus.rsp_rdata),   32'h0);
        check({tag, " rsp_err"},     32'(bus.rsp_err),     32'h0);
        check({tag, " rsp_timeout"}, 32'(bus.rsp_timeout), 32'h0);
    endtask

    initial begin
        preset        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        tick();
        tick();
        check_idle_rst("reset");
        preset = 1'b0;
        #1;
        check("reset cmd_ready", 32'(bus.cmd_ready), 32'h1);

        // Read addr 2 with no wait states. The wdata must not reach pwdata.
        bus.pready = 1'b1;
        bus.prdata = 8'h5A;
        issue(1'b0, 3'd2, 8'hFF);
        tick();                                   // accept edge
        bus.cmd_valid = 1'b0;
        check("rd setup psel_x",  32'(bus.psel_x),  32'h1);
        check("rd setup penable", 32'(bus.penable), 32'h0);
        check("rd setup paddr",   32'(bus.paddr),   32'h2);
        check("rd setup pwrite",  32'(bus.pwrite),  32'h0);
        check("rd setup pwdata",  32'(bus.pwdata),  32'h0);
        #1;
        check("rd setup cmd_ready", 32'(bus.cmd_ready), 32'h0);
        tick();
        check("rd access psel_x",  32'(bus.psel_x),   32'h1);
        check("rd access penable", 32'(bus.penable),  32'h1);
        check("rd access rsp",     32'(bus.rsp_valid), 32'h0);
        tick();
        check("rd done psel_x",    32'(bus.psel_x),    32'h0);
        check("rd done penable",   32'(bus.penable),   32'h0);
        check("rd rsp_valid",      32'(bus.rsp_valid), 32'h1);
        check("rd rsp_rdata",      32'(bus.rsp_rdata), 32'h5A);
        check("rd rsp_err",        32'(bus.rsp_err),   32'h0);
        tick();
        check("rd rsp pulse end",  32'(bus.rsp_valid), 32'h0);

        // Write 0x33 to ERR_STATUS. The completer answers with pslverr. cmd_wdata
        // changes after acceptance and must have no effect.
        bus.pslverr = 1'b1;
        bus.prdata  = 8'hAA;
        issue(1'b1, 3'd1, 8'h33);
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_wdata = 8'h99;
        check("wr setup pwdata", 32'(bus.pwdata), 32'h33);
        check("wr setup pwrite", 32'(bus.pwrite), 32'h1);
        check("wr setup paddr",  32'(bus.paddr),  32'h1);
        tick();
        check("wr access pwdata",  32'(bus.pwdata),  32'h33);
        check("wr access penable", 32'(bus.penable), 32'h1);
        tick();
        bus.pslverr = 1'b0;
        check("wr rsp_valid",   32'(bus.rsp_valid),   32'h1);
        check("wr rsp_err",     32'(bus.rsp_err),     32'h1);
        check("wr rsp_rdata",   32'(bus.rsp_rdata),   32'h0);
        check("wr rsp_timeout", 32'(bus.rsp_timeout), 32'h0);
        tick();

        // Back-to-back writes: addr 2 with 0x11, then addr 3 with 0x22.
        issue(1'b1, 3'd2, 8'h11);
        tick();                                   // first accept
        issue(1'b1, 3'd3, 8'h22);
        #1;
        check("b2b setup cmd_ready", 32'(bus.cmd_ready), 32'h0);
        tick();
        check("b2b acc1 paddr",   32'(bus.paddr),   32'h2);
        check("b2b acc1 pwdata",  32'(bus.pwdata),  32'h11);
        check("b2b acc1 penable", 32'(bus.penable), 32'h1);
        check("b2b acc1 cmd_ready", 32'(bus.cmd_ready), 32'h1);
        tick();                                   // first completes, second accepted
        bus.cmd_valid = 1'b0;
        check("b2b setup2 psel_x",  32'(bus.psel_x),    32'h1);
        check("b2b setup2 penable", 32'(bus.penable),   32'h0);
        check("b2b setup2 paddr",   32'(bus.paddr),     32'h3);
        check("b2b setup2 pwdata",  32'(bus.pwdata),    32'h22);
        check("b2b rsp1 valid",     32'(bus.rsp_valid), 32'h1);
        check("b2b rsp1 err",       32'(bus.rsp_err),   32'h0);
        tick();
        check("b2b acc2 psel_x",  32'(bus.psel_x),    32'h1);
        check("b2b acc2 rsp gap", 32'(bus.rsp_valid), 32'h0);
        tick();
        check("b2b rsp2 valid",   32'(bus.rsp_valid), 32'h1);
        check("b2b done psel_x",  32'(bus.psel_x),    32'h0);
        tick();

        // Read addr 4 with three wait states. prdata is junk until pready rises.
        bus.pready = 1'b0;
        bus.prdata = 8'hEE;
        issue(1'b0, 3'd4, 8'h00);
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("ws wait%0d penable", i),   32'(bus.penable),   32'h1);
            check($sformatf("ws wait%0d cmd_ready", i), 32'(bus.cmd_ready), 32'h0);
            check($sformatf("ws wait%0d rsp", i),       32'(bus.rsp_valid), 32'h0);
        end
        tick();
        check("ws acc4 penable", 32'(bus.penable), 32'h1);
        bus.pready = 1'b1;
        bus.prdata = 8'h07;
        #1;
        check("ws acc4 cmd_ready", 32'(bus.cmd_ready), 32'h1);
        tick();
        check("ws rsp_valid",   32'(bus.rsp_valid),   32'h1);
        check("ws rsp_rdata",   32'(bus.rsp_rdata),   32'h07);
        check("ws rsp_timeout", 32'(bus.rsp_timeout), 32'h0);
        check("ws done penable", 32'(bus.penable),    32'h0);
        tick();

        // Timeout: pready stays low, and the abort follows the 4th ACCESS cycle.
        bus.pready = 1'b0;
        bus.prdata = 8'h3C;
        issue(1'b0, 3'd5, 8'h00);
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("to access%0d penable", i), 32'(bus.penable), 32'h1);
        end
        issue(1'b1, 3'd6, 8'h44);                 // offered during the aborting cycle
        #1;
        check("to last cmd_ready", 32'(bus.cmd_ready), 32'h0);
        tick();
        check("to psel_x",      32'(bus.psel_x),      32'h0);
        check("to penable",     32'(bus.penable),     32'h0);
        check("to rsp_valid",   32'(bus.rsp_valid),   32'h1);
        check("to rsp_err",     32'(bus.rsp_err),     32'h1);
        check("to rsp_timeout", 32'(bus.rsp_timeout), 32'h1);
        check("to rsp_rdata",   32'(bus.rsp_rdata),   32'h0);
        check("to idle cmd_ready", 32'(bus.cmd_ready), 32'h1);
        bus.pready = 1'b1;
        tick();                                   // accepted from IDLE
        bus.cmd_valid = 1'b0;
        check("post-to paddr",  32'(bus.paddr),  32'h6);
        check("post-to pwdata", 32'(bus.pwdata), 32'h44);
        tick();
        tick();
        check("post-to rsp_valid",   32'(bus.rsp_valid),   32'h1);
        check("post-to rsp_err",     32'(bus.rsp_err),     32'h0);
        check("post-to rsp_timeout", 32'(bus.rsp_timeout), 32'h0);
        tick();

        // Reset during a wait-state ACCESS.
        bus.pready = 1'b0;
        issue(1'b0, 3'd7, 8'h00);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        check("mid penable before rst", 32'(bus.penable), 32'h1);
        preset = 1'b1;
        bus.pready = 1'b1;
        bus.prdata = 8'h55;
        tick();
        check_idle_rst("mid-rst");
        preset = 1'b0;
        tick();
        check("mid-rst no rsp",    32'(bus.rsp_valid), 32'h0);
        check("mid-rst no psel_x", 32'(bus.psel_x),    32'h0);
        bus.prdata = 8'h81;
        issue(1'b0, 3'd3, 8'h00);
        tick();
        bus.cmd_valid = 1'b0;
        check("post-rst paddr", 32'(bus.paddr), 32'h3);
        tick();
        tick();
        check("post-rst rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("post-rst rsp_rdata", 32'(bus.rsp_rdata), 32'h81);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
